// File: rtl/cpu_arith_pkg.sv
// Shared widths, state encoding and constants for the CPU arithmetic section.
package cpu_arith_pkg;

  localparam int DIVD_W = 6;
  localparam int DIVS_W = 4;
  localparam int PART_W = DIVS_W + 1;
  localparam int CNT_W  = 3;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIVD_W - 1);
  localparam logic [DIVD_W-1:0] QSAT     = 6'h3F;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } div_state_t;

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell shared by the arithmetic section.
module fulladder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule

// File: rtl/trialsub5.sv
// 5-bit ripple subtractor A - B built as A + ~B + 1 from full-adder cells.
module trialsub5
  import cpu_arith_pkg::*;
(
  input  logic [PART_W-1:0] i_a,
  input  logic [PART_W-1:0] i_b,
  output logic [PART_W-1:0] o_diff,
  output logic              o_nborrow
);

  logic [PART_W:0] w_carry;

  assign w_carry[0] = 1'b1;

  for (genvar g = 0; g < PART_W; g++) begin : g_bit
    fulladder u_fa (
      .i_a  (i_a[g]),
      .i_b  (~i_b[g]),
      .i_ci (w_carry[g]),
      .o_s  (o_diff[g]),
      .o_co (w_carry[g+1])
    );
  end

  // Carry out of the top cell set means A >= B.
  assign o_nborrow = w_carry[PART_W];

endmodule

// File: rtl/seq_divider_6by4.sv
// Multi-cycle restoring divider: 6-bit / 4-bit unsigned, one quotient bit per clock.
// state  | meaning
// S_IDLE | waiting for start; operands captured on acceptance
// S_RUN  | one restoring step per cycle, six steps in total
// S_FIN  | results registered, done pulses in the following cycle
module seq_divider_6by4
  import cpu_arith_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [DIVD_W-1:0] i_dividend,
  input  logic [DIVS_W-1:0] i_divisor,
  output logic              o_busy,
  output logic              o_done,
  output logic [DIVD_W-1:0] o_quotient,
  output logic [DIVS_W-1:0] o_remainder,
  output logic              o_div_by_zero
);

  div_state_t        r_state;
  div_state_t        w_state_nxt;

  logic [DIVD_W-1:0] r_shreg;
  logic [DIVS_W-1:0] r_divisor;
  logic [PART_W-1:0] r_partial;
  logic [CNT_W-1:0]  r_count;

  logic [DIVD_W-1:0] r_quotient;
  logic [DIVS_W-1:0] r_remainder;
  logic              r_div_by_zero;
  logic              r_done;

  logic [PART_W-1:0] w_shifted;
  logic [PART_W-1:0] w_diff;
  logic              w_nborrow;
  logic              w_unused_partial_msb;

  assign w_shifted = {r_partial[DIVS_W-1:0], r_shreg[DIVD_W-1]};

  trialsub5 u_trialsub5 (
    .i_a       (w_shifted),
    .i_b       ({1'b0, r_divisor}),
    .o_diff    (w_diff),
    .o_nborrow (w_nborrow)
  );

  // The final partial is always below the divisor, so its top bit never reaches the output.
  assign w_unused_partial_msb = r_partial[PART_W-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_divisor == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (r_count == '0) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shreg   <= '0;
      r_divisor <= '0;
      r_partial <= '0;
      r_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_shreg   <= i_dividend;
            r_divisor <= i_divisor;
            r_partial <= '0;
            r_count   <= CNT_LAST;
          end
        end
        S_RUN: begin
          r_partial <= w_nborrow ? w_diff : w_shifted;
          r_shreg   <= {r_shreg[DIVD_W-2:0], w_nborrow};
          if (r_count != '0) begin
            r_count <= r_count - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Results move only on the edge leaving S_FIN, i.e. the edge that raises done.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIN);
      if (r_state == S_FIN) begin
        if (r_divisor == '0) begin
          r_quotient    <= QSAT;
          r_remainder   <= r_shreg[DIVS_W-1:0];
          r_div_by_zero <= 1'b1;
        end else begin
          r_quotient    <= r_shreg;
          r_remainder   <= r_partial[DIVS_W-1:0];
          r_div_by_zero <= 1'b0;
        end
      end
    end
  end

  assign o_busy        = (r_state == S_RUN);
  assign o_done        = r_done;
  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_divider_6by4.sv
// Scoreboard bench for seq_divider_6by4: directed cases, held/ignored start, mid-run reset, full sweep.
module tb_seq_divider_6by4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [5:0] quotient;
  logic [3:0] remainder;
  logic       dbz;

  typedef struct {
    logic [5:0] q;
    logic [3:0] r;
    logic       z;
    int         busy_cycles;
    int         a;
    int         b;
  } exp_t;

  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  logic [5:0] last_q;
  logic [3:0] last_r;
  logic       last_z;
  int         busy_cnt;

  seq_divider_6by4 dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
    .o_busy        (busy),
    .o_done        (done),
    .o_quotient    (quotient),
    .o_remainder   (remainder),
    .o_div_by_zero (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Reference: plain integer division, with the saturating divide-by-zero convention.
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q = 6'd63;
      e.r = 4'(a % 16);
      e.z = 1'b1;
      e.busy_cycles = 0;
    end else begin
      e.q = 6'(a / b);
      e.r = 4'(a % b);
      e.z = 1'b0;
      e.busy_cycles = 6;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
      last_q = '0;
      last_r = '0;
      last_z = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL spurious_done: got q=%0d r=%0d z=%0d with no request outstanding",
                   quotient, remainder, dbz);
        end else begin
          e = sb.pop_front();
          if (quotient !== e.q || remainder !== e.r || dbz !== e.z) begin
            fails++;
            $display("FAIL result %0d/%0d: got q=%0d r=%0d z=%0d, expected q=%0d r=%0d z=%0d",
                     e.a, e.b, quotient, remainder, dbz, e.q, e.r, e.z);
          end
          tests++;
          if (busy_cnt != e.busy_cycles) begin
            fails++;
            $display("FAIL busy_cycles %0d/%0d: got %0d, expected %0d",
                     e.a, e.b, busy_cnt, e.busy_cycles);
          end
          last_q = e.q;
          last_r = e.r;
          last_z = e.z;
        end
        busy_cnt = 0;
      end else begin
        tests++;
        if (quotient !== last_q || remainder !== last_r || dbz !== last_z) begin
          fails++;
          $display("FAIL result_hold: got q=%0d r=%0d z=%0d, expected q=%0d r=%0d z=%0d",
                   quotient, remainder, dbz, last_q, last_r, last_z);
        end
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic do_div(input int a, input int b, input int gap);
    int n;
    bit seen;
    dividend = 6'(a);
    divisor  = 4'(b);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sb.push_back(model(a, b));
    dividend = 6'($urandom_range(0, 63));
    divisor  = 4'($urandom_range(0, 15));
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL done_timeout %0d/%0d: no done within %0d cycles", a, b, n);
    end else if (n != ((b == 0) ? 1 : 7)) begin
      fails++;
      $display("FAIL latency %0d/%0d: got %0d edges after accept, expected %0d",
               a, b, n, (b == 0) ? 1 : 7);
    end
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
  endtask

  initial begin
    int cnt;
    int n;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 6'd0 || remainder !== 4'd0 || dbz !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: busy=%0b done=%0b q=%0d r=%0d z=%0b, expected all 0",
               busy, done, quotient, remainder, dbz);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_div(45, 7, 2);
    do_div(63, 1, 0);
    do_div(63, 15, 1);
    do_div(5, 9, 3);
    do_div(22, 0, 1);
    do_div(10, 3, 2);

    // Start asserted mid-run with new operands must be ignored and not queued.
    dividend = 6'd45;
    divisor  = 4'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sb.push_back(model(45, 7));
    repeat (2) begin
      @(posedge clk); #1;
    end
    dividend = 6'd9;
    divisor  = 4'd2;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    count_dones(10, cnt);
    tests++;
    if (cnt != 1) begin
      fails++;
      $display("FAIL ignored_start: got %0d done pulses, expected 1", cnt);
    end
    count_dones(12, cnt);
    tests++;
    if (cnt != 0) begin
      fails++;
      $display("FAIL no_queued_start: got %0d extra done pulses, expected 0", cnt);
    end

    // Start held high re-triggers on each return to idle.
    dividend = 6'd12;
    divisor  = 4'd5;
    start    = 1'b1;
    sb.push_back(model(12, 5));
    sb.push_back(model(12, 5));
    cnt = 0;
    n = 0;
    while (cnt < 2 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done) cnt++;
    end
    start = 1'b0;
    tests++;
    if (cnt != 2) begin
      fails++;
      $display("FAIL held_start: got %0d done pulses in %0d cycles, expected 2", cnt, n);
    end
    repeat (2) begin
      @(posedge clk); #1;
    end

    // Reset in the middle of a run discards the operation.
    do_div(45, 7, 1);
    dividend = 6'd20;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 6'd0 || remainder !== 4'd0 || dbz !== 1'b0) begin
      fails++;
      $display("FAIL midrun_reset: busy=%0b done=%0b q=%0d r=%0d z=%0b, expected all 0",
               busy, done, quotient, remainder, dbz);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    count_dones(10, cnt);
    tests++;
    if (cnt != 0) begin
      fails++;
      $display("FAIL reset_discard: got %0d done pulses after reset, expected 0", cnt);
    end
    do_div(20, 3, 1);

    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_div(a, b, $urandom_range(0, 3));
      end
    end

    repeat (3) begin
      @(posedge clk); #1;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d expected results never produced, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
